// File: rtl/aux_arbiter.sv
// rtl/aux_arbiter.sv - two-master round-robin arbiter for the aux bus
// Tags requests with their source, routes read responses back, and limits outstanding reads.
module aux_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_request,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  input  logic [7:0]  m0_tag,
  input  logic        m0_abort,
  output logic        m0_ready,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic [7:0]  m0_rtag,
  input  logic        m1_request,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  input  logic [7:0]  m1_tag,
  input  logic        m1_abort,
  output logic        m1_ready,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [7:0]  m1_rtag,
  output logic        aux_request,
  output logic        aux_write,
  output logic [31:0] aux_addr,
  output logic [3:0]  aux_wstrb,
  output logic [31:0] aux_wdata,
  output logic [8:0]  aux_tag,
  output logic        aux_abort,
  input  logic        aux_rvalid,
  input  logic [31:0] aux_rdata,
  input  logic [8:0]  aux_rtag,
  output logic        protocol_error
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  logic [3:0] out0_q, out1_q;
  logic       last_grant_q, last_src_q, last_valid_q, last_is_read_q;
  logic       elig0, elig1, grant0, grant1, any_acc;
  logic       sel_write;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb;
  logic [7:0]  sel_tag;
  logic       resp0, resp1, abort_rd0, abort_rd1;

  // Counter update with all same-cycle events netted; never wraps below zero.
  function automatic logic [3:0] next_count(input logic [3:0] cur, input logic inc,
                                            input logic resp, input logic ab);
    logic [4:0] up;
    logic [4:0] down;
    up   = {1'b0, cur} + {4'b0, inc};
    down = {4'b0, resp} + {4'b0, ab};
    return (up > down) ? 4'(up - down) : 4'd0;
  endfunction

  assign elig0 = m0_request && (out0_q < MAX_CNT);
  assign elig1 = m1_request && (out1_q < MAX_CNT);
  assign grant0 = elig0 && (!elig1 || last_grant_q);
  assign grant1 = elig1 && (!elig0 || !last_grant_q);
  assign m0_ready = grant0;
  assign m1_ready = grant1;
  assign any_acc  = grant0 || grant1;

  always_comb begin
    sel_write = m0_write;
    sel_addr  = m0_addr;
    sel_wstrb = m0_wstrb;
    sel_wdata = m0_wdata;
    sel_tag   = m0_tag;
    if (grant1) begin
      sel_write = m1_write;
      sel_addr  = m1_addr;
      sel_wstrb = m1_wstrb;
      sel_wdata = m1_wdata;
      sel_tag   = m1_tag;
    end
  end

  // Abort always refers to the request issued on the bus this cycle.
  assign aux_abort = last_valid_q && (last_src_q ? m1_abort : m0_abort);
  assign abort_rd0 = aux_abort && last_is_read_q && !last_src_q;
  assign abort_rd1 = aux_abort && last_is_read_q && last_src_q;
  assign resp0 = aux_rvalid && !aux_rtag[8];
  assign resp1 = aux_rvalid && aux_rtag[8];

  always_ff @(posedge clock) begin
    if (reset) begin
      aux_request    <= 1'b0;
      aux_write      <= 1'b0;
      aux_addr       <= '0;
      aux_wstrb      <= '0;
      aux_wdata      <= '0;
      aux_tag        <= '0;
      m0_rvalid      <= 1'b0;
      m0_rdata       <= '0;
      m0_rtag        <= '0;
      m1_rvalid      <= 1'b0;
      m1_rdata       <= '0;
      m1_rtag        <= '0;
      protocol_error <= 1'b0;
      out0_q         <= '0;
      out1_q         <= '0;
      last_grant_q   <= 1'b1;
      last_src_q     <= 1'b0;
      last_valid_q   <= 1'b0;
      last_is_read_q <= 1'b0;
    end else begin
      aux_request  <= any_acc;
      last_valid_q <= any_acc;
      if (any_acc) begin
        aux_write      <= sel_write;
        aux_addr       <= sel_addr;
        aux_wstrb      <= sel_wstrb;
        aux_wdata      <= sel_wdata;
        aux_tag        <= {grant1, sel_tag};
        last_grant_q   <= grant1;
        last_src_q     <= grant1;
        last_is_read_q <= !sel_write;
      end
      m0_rvalid <= resp0;
      m1_rvalid <= resp1;
      if (resp0) begin
        m0_rdata <= aux_rdata;
        m0_rtag  <= aux_rtag[7:0];
      end
      if (resp1) begin
        m1_rdata <= aux_rdata;
        m1_rtag  <= aux_rtag[7:0];
      end
      out0_q <= next_count(out0_q, grant0 && !m0_write, resp0, abort_rd0);
      out1_q <= next_count(out1_q, grant1 && !m1_write, resp1, abort_rd1);
      if ((resp0 && out0_q == 4'd0) || (resp1 && out1_q == 4'd0))
        protocol_error <= 1'b1;
    end
  end

endmodule
